mesi_line_ctrl: RTL

- Per-core MESI coherence controller for a direct-mapped L1 with NUM_LINES lines.
- Holds the 2-bit MESI state of every line and sequences CPU hits and misses.
- Issues snooping-bus transactions (BusRd/BusRdX/BusUpgr) with a request/grant handshake and writes back dirty victims.
- Services remote snoops every cycle; sits between the core's cache datapath and the shared coherence bus.

---
 rtl/mesi_pkg.sv | 52 +++++
 rtl/mesi_state_ram.sv | 40 ++++
 rtl/mesi_line_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mesi_pkg.sv
// Shared types for the MESI line controller: line states, bus ops, FSM states
// and the snoop state-transition function.
package mesi_pkg;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_M = 2'd1,
        MESI_S = 2'd2,
        MESI_E = 2'd3
    } mesi_state_t;

    typedef enum logic [1:0] {
        BUS_RD   = 2'd0,
        BUS_RDX  = 2'd1,
        BUS_UPGR = 2'd2
    } bus_op_t;

    typedef enum logic [1:0] {
        FSM_IDLE    = 2'd0,
        FSM_WB      = 2'd1,
        FSM_BUS_REQ = 2'd2,
        FSM_DONE    = 2'd3
    } fsm_state_t;

    typedef struct packed {
        mesi_state_t state;
        logic        flush;
    } snoop_res_t;

    // New local state after observing a remote op; flush marks a dirty supply.
    function automatic snoop_res_t next_state_snoop(input mesi_state_t st, input bus_op_t op);
        snoop_res_t r;
        r.state = st;
        r.flush = 1'b0;
        if (st != MESI_I) begin
            case (op)
                BUS_RD: begin
                    r.flush = (st == MESI_M);
                    r.state = MESI_S;
                end
                BUS_RDX: begin
                    r.flush = (st == MESI_M);
                    r.state = MESI_I;
                end
                BUS_UPGR: r.state = MESI_I;
                default:  r.state = st;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/mesi_state_ram.sv
// Per-line MESI state storage: two combinational read ports, CPU and snoop
// write ports; the snoop write wins when both target the same line.
module mesi_state_ram
    import mesi_pkg::*;
#(
    parameter  int unsigned NUM_LINES = 16,
    localparam int unsigned IDX_W     = $clog2(NUM_LINES)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [IDX_W-1:0]  cpu_ridx_i,
    output mesi_state_t       cpu_rstate_o,
    input  logic [IDX_W-1:0]  snp_ridx_i,
    output mesi_state_t       snp_rstate_o,
    input  logic              cpu_we_i,
    input  logic [IDX_W-1:0]  cpu_widx_i,
    input  mesi_state_t       cpu_wstate_i,
    input  logic              snp_we_i,
    input  logic [IDX_W-1:0]  snp_widx_i,
    input  mesi_state_t       snp_wstate_i
);

    mesi_state_t state_q [NUM_LINES];

    assign cpu_rstate_o = state_q[cpu_ridx_i];
    assign snp_rstate_o = state_q[snp_ridx_i];

    // Snoop write is issued last so it overrides a same-index CPU write.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_LINES; i++) begin
                state_q[i] <= MESI_I;
            end
        end else begin
            if (cpu_we_i) state_q[cpu_widx_i] <= cpu_wstate_i;
            if (snp_we_i) state_q[snp_widx_i] <= snp_wstate_i;
        end
    end

endmodule

// File: rtl/mesi_line_ctrl.sv
// Per-core MESI coherence controller: sequences CPU hits/misses over a
// snooping bus, writes back dirty victims and services remote snoops.
module mesi_line_ctrl
    import mesi_pkg::*;
#(
    parameter  int unsigned NUM_LINES = 16,
    localparam int unsigned IDX_W     = $clog2(NUM_LINES)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cpu_req_valid_i,
    output logic              cpu_req_ready_o,
    input  logic [IDX_W-1:0]  cpu_req_idx_i,
    input  logic              cpu_req_we_i,
    input  logic              cpu_hit_i,
    output logic              cpu_done_o,
    output logic              cpu_rden_o,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [IDX_W-1:0]  wb_idx_o,
    output logic              bus_req_valid_o,
    output logic [1:0]        bus_req_op_o,
    output logic [IDX_W-1:0]  bus_req_idx_o,
    input  logic              bus_gnt_i,
    input  logic              bus_shared_i,
    input  logic              snoop_valid_i,
    input  logic [1:0]        snoop_op_i,
    input  logic [IDX_W-1:0]  snoop_idx_i,
    input  logic              snoop_hit_i,
    output logic              snoop_shared_o,
    output logic              snoop_flush_o,
    output logic [1:0]        line_state_o
);

    fsm_state_t       fsm_q, fsm_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    bus_op_t          op_q, op_d;

    mesi_state_t      cpu_st, snp_st, cpu_wst;
    logic             cpu_we;
    logic [IDX_W-1:0] cpu_widx;
    snoop_res_t       snp_res;
    bus_op_t          snoop_op;
    logic             snp_upd, snp_on_req, snp_on_cpu, cpu_live, collision;

    mesi_state_ram #(.NUM_LINES(NUM_LINES)) u_ram (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cpu_ridx_i   (cpu_req_idx_i),
        .cpu_rstate_o (cpu_st),
        .snp_ridx_i   (snoop_idx_i),
        .snp_rstate_o (snp_st),
        .cpu_we_i     (cpu_we),
        .cpu_widx_i   (cpu_widx),
        .cpu_wstate_i (cpu_wst),
        .snp_we_i     (snp_upd),
        .snp_widx_i   (snoop_idx_i),
        .snp_wstate_i (snp_res.state)
    );

    assign snoop_op   = bus_op_t'(snoop_op_i);
    assign snp_upd    = snoop_valid_i & snoop_hit_i & (snp_st != MESI_I);
    assign snp_res    = next_state_snoop(snp_st, snoop_op);
    assign snp_on_req = snp_upd & (snoop_idx_i == idx_q);
    assign snp_on_cpu = snp_upd & (snoop_idx_i == cpu_req_idx_i);
    assign cpu_live   = cpu_hit_i & (cpu_st != MESI_I);
    // A write hit racing a snoop on its own line is refused and retried next cycle.
    assign collision  = cpu_req_we_i & cpu_live & snp_on_cpu;

    assign snoop_shared_o  = snp_upd;
    assign snoop_flush_o   = snp_upd & snp_res.flush;
    assign line_state_o    = cpu_st;
    assign cpu_req_ready_o = (fsm_q == FSM_IDLE) & ~collision;
    assign cpu_done_o      = (fsm_q == FSM_DONE);
    assign wb_valid_o      = (fsm_q == FSM_WB);
    assign wb_idx_o        = idx_q;
    assign bus_req_valid_o = (fsm_q == FSM_BUS_REQ);
    assign bus_req_op_o    = op_q;
    assign bus_req_idx_o   = idx_q;
    assign cpu_rden_o      = bus_req_valid_o & bus_gnt_i & (op_q != BUS_UPGR);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fsm_q <= FSM_IDLE;
            idx_q <= '0;
            op_q  <= BUS_RD;
        end else begin
            fsm_q <= fsm_d;
            idx_q <= idx_d;
            op_q  <= op_d;
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        idx_d    = idx_q;
        op_d     = op_q;
        cpu_we   = 1'b0;
        cpu_widx = idx_q;
        cpu_wst  = MESI_I;
        case (fsm_q)
            FSM_IDLE: begin
                if (cpu_req_valid_i && cpu_req_ready_o) begin
                    idx_d = cpu_req_idx_i;
                    op_d  = cpu_req_we_i ? BUS_RDX : BUS_RD;
                    if (cpu_live) begin
                        if (!cpu_req_we_i || cpu_st == MESI_M) begin
                            fsm_d = FSM_DONE;
                        end else if (cpu_st == MESI_E) begin
                            cpu_we   = 1'b1;
                            cpu_widx = cpu_req_idx_i;
                            cpu_wst  = MESI_M;
                            fsm_d    = FSM_DONE;
                        end else begin
                            op_d  = BUS_UPGR;
                            fsm_d = FSM_BUS_REQ;
                        end
                    end else if (cpu_st == MESI_M && !snp_on_cpu) begin
                        fsm_d = FSM_WB;
                    end else begin
                        fsm_d = FSM_BUS_REQ;
                    end
                end
            end
            FSM_WB: begin
                // A snoop on the victim always takes it out of M; the writeback is moot.
                if (wb_ready_i) begin
                    cpu_we = 1'b1;
                    fsm_d  = FSM_BUS_REQ;
                end else if (snp_on_req) begin
                    fsm_d = FSM_BUS_REQ;
                end
            end
            FSM_BUS_REQ: begin
                if (bus_gnt_i) begin
                    cpu_we  = 1'b1;
                    cpu_wst = (op_q != BUS_RD) ? MESI_M
                            : (bus_shared_i ? MESI_S : MESI_E);
                    fsm_d   = FSM_DONE;
                end else if (op_q == BUS_UPGR && snp_on_req &&
                             (snoop_op == BUS_RDX || snoop_op == BUS_UPGR)) begin
                    op_d = BUS_RDX;
                end
            end
            FSM_DONE: fsm_d = FSM_IDLE;
            default:  fsm_d = FSM_IDLE;
        endcase
    end

    a_no_snoop_with_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(snoop_valid_i && bus_gnt_i));
    a_no_upgr_on_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(snp_upd && snoop_op == BUS_UPGR && (snp_st == MESI_M || snp_st == MESI_E)));

endmodule
